aes_block_sequencer: RTL

Control FSM for the AES hardware processing engine (HWPE). It sits between the input streamer source, the AES core and the output streamer sink. It splits a job of `data_size_i` bytes into 128-bit blocks. For each block it gathers four 32-bit words, starts the core, emits the four result words, and waits for the memory-write acknowledgements before moving to the next block.

---
 rtl/aes_package.sv | 31 +++
 rtl/aes_block_buffer.sv | 43 ++++
 rtl/aes_block_sequencer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/aes_package.sv
// rtl/aes_package.sv - shared types and constants for the AES block sequencer
package aes_package;

  localparam int WORD_W          = 32;
  localparam int WORDS_PER_BLOCK = 4;
  localparam int BLOCK_W         = WORD_W * WORDS_PER_BLOCK;
  localparam int IDX_W           = $clog2(WORDS_PER_BLOCK);
  localparam int BLK_CNT_W       = 29;
  localparam int BLK_DONE_W      = 28;

  localparam logic [1:0] AES_KEY_128 = 2'd0;
  localparam logic [1:0] AES_KEY_192 = 2'd1;
  localparam logic [1:0] AES_KEY_256 = 2'd2;

  typedef enum logic [3:0] {
    IDLE,
    STARTING,
    REQUEST_DATA,
    REQUEST_DATA_WAIT,
    WORKING,
    SEND_DATA,
    SEND_DATA_WAIT,
    MEMORY_WRITE_WAIT,
    FINISHED
  } aes_state_t;

  function automatic logic key_mode_valid(input logic [1:0] mode);
    return (mode == AES_KEY_128) || (mode == AES_KEY_192) || (mode == AES_KEY_256);
  endfunction

endpackage

// File: rtl/aes_block_buffer.sv
// rtl/aes_block_buffer.sv - 4x32 word register with indexed write, block load and indexed read
module aes_block_buffer
  import aes_package::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clear_i,
  input  logic               wr_en_i,
  input  logic [IDX_W-1:0]   wr_idx_i,
  input  logic [WORD_W-1:0]  wr_data_i,
  input  logic               load_en_i,
  input  logic [BLOCK_W-1:0] load_data_i,
  input  logic [IDX_W-1:0]   rd_idx_i,
  output logic [WORD_W-1:0]  rd_data_o,
  output logic [BLOCK_W-1:0] block_o
);

  // Word index 0 is the most significant word, so index i lives in slot ~i.
  logic [WORDS_PER_BLOCK-1:0][WORD_W-1:0] words_q, words_d;

  always_comb begin
    words_d = words_q;
    if (clear_i) begin
      words_d = '0;
    end else if (load_en_i) begin
      words_d = load_data_i;
    end else if (wr_en_i) begin
      words_d[~wr_idx_i] = wr_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      words_q <= '0;
    end else begin
      words_q <= words_d;
    end
  end

  assign rd_data_o = words_q[~rd_idx_i];
  assign block_o   = words_q;

endmodule

// File: rtl/aes_block_sequencer.sv
// rtl/aes_block_sequencer.sv - splits a job into 128-bit blocks and drives the AES core and streams
module aes_block_sequencer
  import aes_package::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  logic [31:0]           data_size_i,
  input  logic [1:0]            key_mode_i,
  input  logic                  in_valid_i,
  input  logic [WORD_W-1:0]     in_data_i,
  output logic                  in_ready_o,
  output logic                  core_start_o,
  output logic [BLOCK_W-1:0]    core_block_o,
  output logic [1:0]            core_key_size_o,
  input  logic                  core_done_i,
  input  logic [BLOCK_W-1:0]    core_result_i,
  output logic                  out_valid_o,
  output logic [WORD_W-1:0]     out_data_o,
  input  logic                  out_ready_i,
  input  logic                  wr_done_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output aes_state_t            state_o,
  output logic [BLK_DONE_W-1:0] blocks_done_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_BLOCK - 1);
  localparam logic [2:0]       WR_FULL  = 3'(WORDS_PER_BLOCK);

  aes_state_t            state_q, state_d;
  logic [1:0]            key_q, key_d;
  logic [BLK_CNT_W-1:0]  blocks_left_q, blocks_left_d;
  logic [BLK_DONE_W-1:0] blocks_done_q, blocks_done_d;
  logic [IDX_W-1:0]      req_cnt_q, req_cnt_d;
  logic [IDX_W-1:0]      send_cnt_q, send_cnt_d;
  logic [2:0]            wr_cnt_q, wr_cnt_d;
  logic                  err_q, err_d;
  logic                  done_q, done_d;

  logic                  in_wr;
  logic                  res_load;
  logic [2:0]            wr_cnt_inc;
  logic [WORD_W-1:0]     unused_in_word;
  logic [BLOCK_W-1:0]    unused_res_block;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      key_q         <= '0;
      blocks_left_q <= '0;
      blocks_done_q <= '0;
      req_cnt_q     <= '0;
      send_cnt_q    <= '0;
      wr_cnt_q      <= '0;
      err_q         <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      key_q         <= key_d;
      blocks_left_q <= blocks_left_d;
      blocks_done_q <= blocks_done_d;
      req_cnt_q     <= req_cnt_d;
      send_cnt_q    <= send_cnt_d;
      wr_cnt_q      <= wr_cnt_d;
      err_q         <= err_d;
      done_q        <= done_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    key_d         = key_q;
    blocks_left_d = blocks_left_q;
    blocks_done_d = blocks_done_q;
    req_cnt_d     = req_cnt_q;
    send_cnt_d    = send_cnt_q;
    wr_cnt_d      = wr_cnt_q;
    err_d         = err_q;
    done_d        = 1'b0;
    in_wr         = 1'b0;
    res_load      = 1'b0;
    // Includes this cycle's pulse so the last write releases the block without an extra cycle.
    wr_cnt_inc    = (wr_cnt_q == WR_FULL) ? WR_FULL : wr_cnt_q + {2'b00, wr_done_i};

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          key_d         = key_mode_i;
          blocks_left_d = BLK_CNT_W'(({1'b0, data_size_i} + 33'd15) >> 4);
          blocks_done_d = '0;
          err_d         = 1'b0;
          state_d       = STARTING;
        end
      end
      STARTING: begin
        if (!key_mode_valid(key_q)) begin
          err_d   = 1'b1;
          state_d = FINISHED;
        end else if (blocks_left_q == '0) begin
          state_d = FINISHED;
        end else begin
          req_cnt_d = '0;
          state_d   = REQUEST_DATA;
        end
      end
      REQUEST_DATA: begin
        if (in_valid_i) begin
          in_wr     = 1'b1;
          req_cnt_d = req_cnt_q + 1'b1;
          if (req_cnt_q == LAST_IDX) begin
            state_d = REQUEST_DATA_WAIT;
          end
        end
      end
      REQUEST_DATA_WAIT: begin
        state_d = WORKING;
      end
      WORKING: begin
        if (core_done_i) begin
          res_load   = 1'b1;
          send_cnt_d = '0;
          wr_cnt_d   = '0;
          state_d    = SEND_DATA;
        end
      end
      SEND_DATA, SEND_DATA_WAIT: begin
        wr_cnt_d = wr_cnt_inc;
        if (out_ready_i) begin
          send_cnt_d = send_cnt_q + 1'b1;
          state_d    = (send_cnt_q == LAST_IDX) ? MEMORY_WRITE_WAIT : SEND_DATA;
        end else begin
          state_d = SEND_DATA_WAIT;
        end
      end
      MEMORY_WRITE_WAIT: begin
        wr_cnt_d = wr_cnt_inc;
        if (wr_cnt_inc == WR_FULL) begin
          blocks_left_d = blocks_left_q - 1'b1;
          blocks_done_d = blocks_done_q + 1'b1;
          wr_cnt_d      = '0;
          req_cnt_d     = '0;
          state_d       = (blocks_left_q == BLK_CNT_W'(1)) ? FINISHED : REQUEST_DATA;
        end
      end
      FINISHED: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (clear_i) begin
      state_d       = IDLE;
      key_d         = '0;
      blocks_left_d = '0;
      blocks_done_d = '0;
      req_cnt_d     = '0;
      send_cnt_d    = '0;
      wr_cnt_d      = '0;
      err_d         = 1'b0;
      done_d        = 1'b0;
      in_wr         = 1'b0;
      res_load      = 1'b0;
    end
  end

  always_comb begin
    in_ready_o      = (state_q == REQUEST_DATA);
    core_start_o    = (state_q == REQUEST_DATA_WAIT);
    out_valid_o     = (state_q == SEND_DATA) || (state_q == SEND_DATA_WAIT);
    busy_o          = (state_q != IDLE);
    done_o          = done_q;
    err_o           = err_q;
    state_o         = state_q;
    blocks_done_o   = blocks_done_q;
    core_key_size_o = key_q;
  end

  aes_block_buffer u_in_buf (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (clear_i),
    .wr_en_i     (in_wr),
    .wr_idx_i    (req_cnt_q),
    .wr_data_i   (in_data_i),
    .load_en_i   (1'b0),
    .load_data_i ('0),
    .rd_idx_i    ('0),
    .rd_data_o   (unused_in_word),
    .block_o     (core_block_o)
  );

  aes_block_buffer u_res_buf (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (clear_i),
    .wr_en_i     (1'b0),
    .wr_idx_i    ('0),
    .wr_data_i   ('0),
    .load_en_i   (res_load),
    .load_data_i (core_result_i),
    .rd_idx_i    (send_cnt_q),
    .rd_data_o   (out_data_o),
    .block_o     (unused_res_block)
  );

endmodule
